// File: rtl/temp_bcd_formatter.sv
// Signed 8-bit Celsius to sign/hundreds/tens/ones display codes via sequential double-dabble.
// Optional min/max recall selected by `define TEMP_MINMAX_EN (adds show_sel input).
module temp_bcd_formatter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [3:0]  BLANK_CODE    = 4'hA,
    parameter logic [3:0]  MINUS_CODE    = 4'hB
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef TEMP_MINMAX_EN
    input  logic [1:0] show_sel,
`endif
    input  logic [7:0] temp_in,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       digits_valid,
    output logic       update,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  last_val_q, last_val_d;
    logic [7:0]  prev_q, prev_d;
    logic        restart_q, restart_d;
    logic        first_q, first_d;
    logic [7:0]  stable_cnt_q, stable_cnt_d;
    logic        neg_q, neg_d;
    logic [19:0] shreg_q, shreg_d;
    logic [3:0]  iter_q, iter_d;
    logic [3:0]  dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d;
    logic        valid_q, valid_d;
    logic        update_q, update_d;

    logic [7:0]  src_val;
    logic [7:0]  mag;
    logic        sel_same;
    logic        sel_changed;
    logic        same_in;
    logic [11:0] bcd_adj;

`ifdef TEMP_MINMAX_EN
    logic [7:0] min_q, min_d, max_q, max_d;
    logic [1:0] last_sel_q, last_sel_d, prev_sel_q, prev_sel_d;
    logic [7:0] min_cand, max_cand;

    // Extremes include the value being latched now, so selecting min/max shows it immediately.
    always_comb begin
        min_cand = (first_q || ($signed(temp_in) < $signed(min_q))) ? temp_in : min_q;
        max_cand = (first_q || ($signed(temp_in) > $signed(max_q))) ? temp_in : max_q;
        case (show_sel)
            2'd1:    src_val = min_cand;
            2'd2:    src_val = max_cand;
            default: src_val = temp_in;
        endcase
        sel_same    = (show_sel == prev_sel_q);
        sel_changed = (show_sel != last_sel_q);
    end
`else
    always_comb begin
        src_val     = temp_in;
        sel_same    = 1'b1;
        sel_changed = 1'b0;
    end
`endif

    // -128 negates to 8'h80, which read unsigned is the required magnitude 128.
    assign mag = src_val[7] ? (~src_val + 8'd1) : src_val;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (shreg_q[8 + gi*4 +: 4] >= 4'd5)
                                        ? shreg_q[8 + gi*4 +: 4] + 4'd3
                                        : shreg_q[8 + gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        last_val_d   = last_val_q;
        prev_d       = prev_q;
        restart_d    = restart_q;
        first_d      = first_q;
        stable_cnt_d = stable_cnt_q;
        neg_d        = neg_q;
        shreg_d      = shreg_q;
        iter_d       = iter_q;
        dig0_d       = dig0_q;
        dig1_d       = dig1_q;
        dig2_d       = dig2_q;
        dig3_d       = dig3_q;
        valid_d      = valid_q;
        update_d     = 1'b0;
        same_in      = 1'b0;
`ifdef TEMP_MINMAX_EN
        min_d        = min_q;
        max_d        = max_q;
        last_sel_d   = last_sel_q;
        prev_sel_d   = prev_sel_q;
`endif
        case (state_q)
            IDLE: begin
                // restart_q makes the first idle cycle count as a change, restarting the filter.
                same_in      = (temp_in == prev_q) && sel_same && !restart_q;
                stable_cnt_d = same_in ? ((stable_cnt_q == 8'hFF) ? 8'hFF : stable_cnt_q + 8'd1)
                                       : 8'd0;
                prev_d       = temp_in;
                restart_d    = 1'b0;
`ifdef TEMP_MINMAX_EN
                prev_sel_d   = show_sel;
`endif
                if ((first_q || (temp_in != last_val_q) || sel_changed) &&
                    (stable_cnt_d >= STABLE_LAST)) begin
                    last_val_d   = temp_in;
                    neg_d        = src_val[7];
                    shreg_d      = {12'd0, mag};
                    first_d      = 1'b0;
                    iter_d       = 4'd0;
                    stable_cnt_d = 8'd0;
                    state_d      = CONV;
`ifdef TEMP_MINMAX_EN
                    min_d        = min_cand;
                    max_d        = max_cand;
                    last_sel_d   = show_sel;
`endif
                end
            end
            CONV: begin
                shreg_d = {bcd_adj, shreg_q[7:0]} << 1;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd7) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                dig0_d    = shreg_q[11:8];
                dig1_d    = ((shreg_q[19:16] == 4'd0) && (shreg_q[15:12] == 4'd0))
                            ? BLANK_CODE : shreg_q[15:12];
                dig2_d    = (shreg_q[19:16] == 4'd0) ? BLANK_CODE : shreg_q[19:16];
                dig3_d    = neg_q ? MINUS_CODE : BLANK_CODE;
                valid_d   = 1'b1;
                update_d  = 1'b1;
                restart_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_val_q   <= 8'h00;
            prev_q       <= 8'h00;
            restart_q    <= 1'b1;
            first_q      <= 1'b1;
            stable_cnt_q <= 8'd0;
            neg_q        <= 1'b0;
            shreg_q      <= 20'd0;
            iter_q       <= 4'd0;
            dig0_q       <= 4'd0;
            dig1_q       <= BLANK_CODE;
            dig2_q       <= BLANK_CODE;
            dig3_q       <= BLANK_CODE;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
`ifdef TEMP_MINMAX_EN
            min_q        <= 8'h00;
            max_q        <= 8'h00;
            last_sel_q   <= 2'd0;
            prev_sel_q   <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_val_q   <= last_val_d;
            prev_q       <= prev_d;
            restart_q    <= restart_d;
            first_q      <= first_d;
            stable_cnt_q <= stable_cnt_d;
            neg_q        <= neg_d;
            shreg_q      <= shreg_d;
            iter_q       <= iter_d;
            dig0_q       <= dig0_d;
            dig1_q       <= dig1_d;
            dig2_q       <= dig2_d;
            dig3_q       <= dig3_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
`ifdef TEMP_MINMAX_EN
            min_q        <= min_d;
            max_q        <= max_d;
            last_sel_q   <= last_sel_d;
            prev_sel_q   <= prev_sel_d;
`endif
        end
    end

    assign dig0         = dig0_q;
    assign dig1         = dig1_q;
    assign dig2         = dig2_q;
    assign dig3         = dig3_q;
    assign digits_valid = valid_q;
    assign update       = update_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_temp_bcd_formatter.sv
// Directed bench for temp_bcd_formatter: an arithmetic reference model checked every cycle,
// plus literal expectations for the documented display patterns and timing boundaries.
module tb_temp_bcd_formatter;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] temp_in;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       digits_valid, update, busy;
`ifdef TEMP_MINMAX_EN
    logic [1:0] show_sel = 2'd0;
`endif

    int checks = 0;
    int errors = 0;

    temp_bcd_formatter #(.STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef TEMP_MINMAX_EN
        .show_sel     (show_sel),
`endif
        .temp_in      (temp_in),
        .dig0         (dig0),
        .dig1         (dig1),
        .dig2         (dig2),
        .dig3         (dig3),
        .digits_valid (digits_valid),
        .update       (update),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: display codes from integer arithmetic, timing from a sample window.
    logic [15:0] exp_dig;
    logic        exp_valid, exp_upd, exp_busy;
    logic        m_first;
    logic [7:0]  m_last;
    logic [15:0] m_pending;
    int          busy_left;
    logic [7:0]  win[$];
    logic        model_ready = 1'b0;

    function automatic logic [15:0] fmt(input logic [7:0] t);
        int v, a, h, te, o;
        logic [3:0] d3, d2, d1, d0;
        v  = int'($signed(t));
        a  = (v < 0) ? -v : v;
        h  = a / 100;
        te = (a / 10) % 10;
        o  = a % 10;
        d3 = (v < 0) ? 4'hB : 4'hA;
        d2 = (h == 0) ? 4'hA : 4'(h);
        d1 = (h == 0 && te == 0) ? 4'hA : 4'(te);
        d0 = 4'(o);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_reset();
        exp_dig   = 16'hAAA0;
        exp_valid = 1'b0;
        exp_upd   = 1'b0;
        exp_busy  = 1'b0;
        m_first   = 1'b1;
        m_last    = 8'h00;
        busy_left = 0;
        win.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                model_ready = 1'b1;
            end else begin
                exp_upd = 1'b0;
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        exp_dig   = m_pending;
                        exp_valid = 1'b1;
                        exp_upd   = 1'b1;
                        exp_busy  = 1'b0;
                        win.delete();
                    end
                end else begin
                    logic ok;
                    win.push_back(temp_in);
                    if (win.size() > 300) void'(win.pop_front());
                    ok = (m_first || temp_in != m_last) && (win.size() >= S);
                    if (ok) begin
                        for (int i = win.size() - S; i < win.size(); i++)
                            if (win[i] != temp_in) ok = 1'b0;
                    end
                    if (ok) begin
                        m_last    = temp_in;
                        m_first   = 1'b0;
                        m_pending = fmt(temp_in);
                        busy_left = 9;
                        exp_busy  = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                checks++;
                if ({dig3, dig2, dig1, dig0, digits_valid, update, busy} !==
                    {exp_dig, exp_valid, exp_upd, exp_busy}) begin
                    errors++;
                    $display("FAIL cycle_model t=%0t: got dig=%h v=%b u=%b b=%b expected dig=%h v=%b u=%b b=%b",
                             $time, {dig3, dig2, dig1, dig0}, digits_valid, update, busy,
                             exp_dig, exp_valid, exp_upd, exp_busy);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic wait_update(input string name, input logic [15:0] req, output int edges);
        edges = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (update) begin
                edges = k;
                break;
            end
        end
        if (edges == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no update expected update within 80 cycles", name);
        end else begin
            $display("update %s: dig3..0=%h valid=%b after %0d edges", name,
                     {dig3, dig2, dig1, dig0}, digits_valid, edges);
            check_lit(name, {15'd0, digits_valid, dig3, dig2, dig1, dig0}, {15'd0, 1'b1, req});
        end
    endtask

    task automatic wait_busy(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check_lit({name, "_busy"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic count_pulses(input string name, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (update || busy) n++;
        end
        $display("quiet %s: %0d active cycles in %0d", name, n, cycles);
        check_lit(name, n, 0);
    endtask

    initial begin
        int e;
        int low;
        rst_n   = 1'b1;
        temp_in = 8'h19;
        #1 rst_n = 1'b0;
        #2 check_lit("reset_state", {13'd0, dig3, dig2, dig1, dig0, digits_valid, update, busy},
                     {13'd0, 16'hAAA0, 3'b000});
        @(posedge clk); #2 rst_n = 1'b1;

        wait_update("pos25", 16'hAA25, e);
        check_lit("first_latency", e, S + 9);

        temp_in = 8'hFB;
        wait_update("neg5", 16'hBAA5, e);
        temp_in = 8'h80;
        wait_update("neg128", 16'hB128, e);
        temp_in = 8'h64;
        wait_update("pos100", 16'hA100, e);
        temp_in = 8'h19;
        wait_update("pos25b", 16'hAA25, e);

        // Two-cycle glitch must not start a conversion.
        @(posedge clk); #2 temp_in = 8'h1A;
        @(posedge clk);
        @(posedge clk); #2 temp_in = 8'h19;
        count_pulses("glitch", 30);

        // Input change during conversion is picked up only afterwards.
        temp_in = 8'h64;
        wait_update("pos100b", 16'hA100, e);
        temp_in = 8'h19;
        wait_busy("conv_change");
        repeat (3) @(posedge clk);
        #2 temp_in = 8'h1E;
        wait_update("pos25c", 16'hAA25, e);
        low = busy ? 0 : 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (busy) break;
            low++;
        end
        $display("gap: busy low for %0d cycles", low);
        check_lit("busy_gap", {31'd0, low >= S}, 32'd1);
        wait_update("pos30", 16'hAA30, e);

        // Reset at E4 aborts; held input reconverts afterwards.
        temp_in = 8'h64;
        wait_busy("abort");
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_lit("abort_reset", {13'd0, dig3, dig2, dig1, dig0, digits_valid, update, busy},
                     {13'd0, 16'hAAA0, 3'b000});
        @(posedge clk); #2 rst_n = 1'b1;
        wait_update("reconvert", 16'hA100, e);
        check_lit("reconvert_latency", e, S + 9);

        // Zero first after reset converts once, then stays quiet.
        temp_in = 8'h00;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        wait_update("zero", 16'hAAA0, e);
        count_pulses("zero_hold", 40);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
